// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Constants and helpers shared by the transaction-layer FIFO controller
//   and its storage array.
//   - DEFAULT_MEM_DEPTH : default number of FIFO entries (power of two, >= 2)
//   - WORD_SIZE         : width of one stored word
//   - ptr_size()        : address width for a given depth
//   - cnt_size()        : occupancy/threshold width for a given depth
//     (one extra bit so that "completely full" is representable)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_MEM_DEPTH = 8;
    localparam int WORD_SIZE         = 10;

    function automatic int ptr_size(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_size(input int depth);
        return ptr_size(depth) + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
//   Wrap-around address counter used for both the write and the read pointer
//   of the FIFO. Because the FIFO depth is a power of two, the natural
//   roll-over of a PTR_SIZE-bit register is the modulo-depth wrap.
//
// Ports
//   clk      in   single clock, all state on posedge
//   reset_L  in   synchronous active-low reset (pointer -> 0)
//   inc      in   advance the pointer by one this cycle
//   ptr      out  current address, PTR_SIZE bits
// -----------------------------------------------------------------------------
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int PTR_SIZE = ptr_size(DEFAULT_MEM_DEPTH)
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                inc,
    output logic [PTR_SIZE-1:0] ptr
);

    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples its inputs from before the clock edge.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_SIZE'(1);
        end
    end

endmodule : fifo_ptr

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//   Pointer and flag controller for the transaction-layer FIFO. Turns
//   push/pop requests into write/read strobes and addresses for the storage
//   array, tracks occupancy, decodes full/empty/watermark flags, and issues a
//   data_valid strobe aligned with the array's registered read port.
//
//   Build option: define FIFO_CTRL_ERROR_EN to get a sticky error flag set on
//   overflow (push while full without an accepted pop) or underflow (pop
//   while empty). Without it, error is tied to 0. Illegal requests are
//   rejected identically in both builds.
//
// Ports
//   clk           in   single clock
//   reset_L       in   synchronous active-low reset
//   push, pop     in   write / read requests
//   umbral_alto   in   almost-full threshold  (1..MEM_DEPTH)
//   umbral_bajo   in   almost-empty threshold (0..MEM_DEPTH-1)
//   wr_en, rd_en  out  combinational strobes to the storage array
//   wr_ptr,rd_ptr out  storage addresses
//   count         out  occupancy 0..MEM_DEPTH
//   full, empty   out  count==MEM_DEPTH / count==0
//   almost_full   out  count >= umbral_alto
//   almost_empty  out  count <= umbral_bajo
//   data_valid    out  read data valid (cycle after an accepted pop)
//   error         out  sticky overflow/underflow flag (see build option)
// -----------------------------------------------------------------------------
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int PTR_SIZE  = ptr_size(MEM_DEPTH),
    parameter int CNT_SIZE  = PTR_SIZE + 1
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                push,
    input  logic                pop,
    input  logic [CNT_SIZE-1:0] umbral_alto,
    input  logic [CNT_SIZE-1:0] umbral_bajo,
    output logic                wr_en,
    output logic                rd_en,
    output logic [PTR_SIZE-1:0] wr_ptr,
    output logic [PTR_SIZE-1:0] rd_ptr,
    output logic [CNT_SIZE-1:0] count,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                data_valid,
    output logic                error
);

    localparam logic [CNT_SIZE-1:0] DEPTH_CNT = CNT_SIZE'(MEM_DEPTH);

    // Flags are forced to their "reset" view while reset_L is low so that
    // neighbouring stages see an empty FIFO during reset.
    assign full         =  reset_L & (count == DEPTH_CNT);
    assign empty        = ~reset_L | (count == '0);
    assign almost_full  =  reset_L & (count >= umbral_alto);
    assign almost_empty = ~reset_L | (count <= umbral_bajo);

    // A push while full is only accepted when a pop frees the slot in the
    // same cycle; wr_ptr==rd_ptr then and the array returns the old word.
    assign rd_en = reset_L & pop & ~empty;
    assign wr_en = reset_L & push & (~full | rd_en);

    fifo_ptr #(.PTR_SIZE(PTR_SIZE)) u_wr_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (wr_en),
        .ptr     (wr_ptr)
    );

    fifo_ptr #(.PTR_SIZE(PTR_SIZE)) u_rd_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (rd_en),
        .ptr     (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            count      <= '0;
            data_valid <= 1'b0;
        end else begin
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_SIZE'(1);
                2'b01:   count <= count - CNT_SIZE'(1);
                default: count <= count;
            endcase
            data_valid <= rd_en;
        end
    end

`ifdef FIFO_CTRL_ERROR_EN
    logic overflow;
    logic underflow;

    assign overflow  = reset_L & push & full & ~rd_en;
    assign underflow = reset_L & pop & empty;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            error <= 1'b0;
        end else if (overflow | underflow) begin
            error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
//   Self-checking bench for fifo_ctrl. A reference model tracks occupancy as
//   a plain integer and the pointers as total words written/read modulo the
//   depth. Directed sequences cover reset, fill/wrap, overflow, push+pop at
//   full and empty, drain/underflow and reset mid-operation; a randomized
//   phase with varying push/pop bias, thresholds and occasional resets
//   follows. Expected error behaviour follows FIFO_CTRL_ERROR_EN.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam int CW    = 4;

`ifdef FIFO_CTRL_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_L;
    logic          push;
    logic          pop;
    logic [CW-1:0] umbral_alto;
    logic [CW-1:0] umbral_bajo;
    logic          wr_en;
    logic          rd_en;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          data_valid;
    logic          error;

    fifo_ctrl #(.MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .pop          (pop),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_valid   (data_valid),
        .error        (error)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit known    = 1'b0;
    int m_count  = 0;
    int m_writes = 0;
    int m_reads  = 0;
    bit m_dv     = 1'b0;
    bit m_err    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock cycle: drive inputs just after posedge, check just before the
    // next posedge, then advance the model across that edge.
    task automatic step(input bit rst_n, input bit p, input bit q);
        bit e_wr, e_rd, e_full, e_empty, e_af, e_ae;
        reset_L = rst_n;
        push    = p;
        pop     = q;
        #4;
        if (!rst_n) begin
            e_rd = 0; e_wr = 0;
            e_full = 0; e_empty = 1; e_af = 0; e_ae = 1;
        end else begin
            e_empty = (m_count == 0);
            e_full  = (m_count == DEPTH);
            e_af    = (m_count >= int'(umbral_alto));
            e_ae    = (m_count <= int'(umbral_bajo));
            e_rd    = q && (m_count > 0);
            e_wr    = p && ((m_count < DEPTH) || e_rd);
        end
        check("wr_en",        32'(wr_en),        32'(e_wr));
        check("rd_en",        32'(rd_en),        32'(e_rd));
        check("full",         32'(full),         32'(e_full));
        check("empty",        32'(empty),        32'(e_empty));
        check("almost_full",  32'(almost_full),  32'(e_af));
        check("almost_empty", 32'(almost_empty), 32'(e_ae));
        if (known) begin
            check("wr_ptr",     32'(wr_ptr),     32'(m_writes % DEPTH));
            check("rd_ptr",     32'(rd_ptr),     32'(m_reads % DEPTH));
            check("count",      32'(count),      32'(m_count));
            check("data_valid", 32'(data_valid), 32'(m_dv));
            check("error",      32'(error),      32'(m_err));
        end
        @(posedge clk);
        if (!rst_n) begin
            known    = 1'b1;
            m_count  = 0;
            m_writes = 0;
            m_reads  = 0;
            m_dv     = 1'b0;
            m_err    = 1'b0;
        end else begin
            if (ERR_EN && ((p && m_count == DEPTH && !e_rd) || (q && m_count == 0)))
                m_err = 1'b1;
            m_writes += int'(e_wr);
            m_reads  += int'(e_rd);
            m_count  += int'(e_wr) - int'(e_rd);
            m_dv      = e_rd;
        end
        #1;
    endtask

    initial begin
        int bias;
        reset_L     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        umbral_alto = CW'(6);
        umbral_bajo = CW'(2);

        // Reset for two cycles, then one idle cycle to observe reset state.
        step(0, 0, 0);
        step(0, 1, 1);
        step(1, 0, 0);

        // Fill to full with wrap of wr_ptr, then overflow attempt.
        repeat (DEPTH) step(1, 1, 0);
        step(1, 1, 0);
        step(1, 0, 0);

        // Push+pop while full: both advance, count stays at depth.
        step(1, 1, 1);

        // Drain from full plus one underflow pop.
        repeat (DEPTH + 1) step(1, 0, 1);
        step(1, 0, 0);

        // Push+pop while empty: only the push is accepted.
        step(1, 1, 1);
        step(1, 0, 1);

        // Reset mid-operation at count 5.
        repeat (5) step(1, 1, 0);
        step(1, 1, 0);
        step(1, 0, 1);
        step(0, 1, 1);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 0);

        // Randomized phase.
        bias = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) begin
                bias        = int'($urandom_range(10, 90));
                umbral_alto = CW'($urandom_range(1, DEPTH));
                umbral_bajo = CW'($urandom_range(0, DEPTH - 1));
            end
            step($urandom_range(0, 79) != 0,
                 $urandom_range(0, 99) < bias,
                 $urandom_range(0, 99) < (100 - bias));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fifo_ctrl

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the transaction-layer FIFO. It accepts push/pop requests from the neighbouring stages and drives the write/read enables and addresses of the FIFO storage array. It also produces the full, empty and watermark flags, a read-data-valid strobe aligned to the array's registered read port, and an overflow/underflow error indication.

## Interface
- MEM_DEPTH, 8, number of FIFO entries; must be a power of two, ≥ 2
- PTR_SIZE, $clog2(MEM_DEPTH), address width of wr_ptr/rd_ptr
- CNT_SIZE, PTR_SIZE+1, width of occupancy count and thresholds

- clk  in  1  single clock, all state on posedge
- reset_L  in  1  synchronous, active-low reset; sampled on posedge clk
- push  in  1  request to write one word this cycle
- pop  in  1  request to read one word this cycle
- umbral_alto  in  CNT_SIZE  almost-full threshold, legal range 1..MEM_DEPTH
- umbral_bajo  in  CNT_SIZE  almost-empty threshold, legal range 0..MEM_DEPTH-1
- wr_en  out  1  write strobe to storage array
- rd_en  out  1  read strobe to storage array
- wr_ptr  out  PTR_SIZE  write address
- rd_ptr  out  PTR_SIZE  read address
- count  out  CNT_SIZE  current occupancy, 0..MEM_DEPTH
- full, empty  out  1  count==MEM_DEPTH / count==0
- almost_full, almost_empty  out  1  count ≥ umbral_alto / count ≤ umbral_bajo
- data_valid  out  1  storage read data is valid this cycle
- error  out  1  overflow/underflow indication (see Configuration)

## Operation
- rd_en = reset_L & pop & !empty.
- wr_en = reset_L & push & (!full | rd_en): push while full is accepted only if a pop is accepted in the same cycle.
- Both strobes are combinational from the inputs and the registered state.
- On posedge clk, with reset_L=1:
  - wr_ptr += wr_en, modulo MEM_DEPTH.
  - rd_ptr += rd_en, modulo MEM_DEPTH.
  - count += wr_en − rd_en.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- When full, wr_ptr==rd_ptr; the array returns the old word, so push+pop while full is legal.
- Empty with push+pop: push accepted, pop rejected; count becomes 1.
- Wrap-around: a pointer at MEM_DEPTH−1 goes to 0 on its strobe; no other effect.
- Flags are combinational decodes of the registered count. Thresholds are sampled continuously; changing them takes effect the same cycle.
- Overflow event: push & full & !rd_en. Underflow event: pop & empty. Rejected requests do not alter any pointer or count.
- data_valid is a register loaded with rd_en, so it is high the cycle after an accepted pop.

## Timing
- Reset (reset_L=0 at posedge) sets the following registered outputs:
  - wr_ptr=0, rd_ptr=0, count=0
  - data_valid=0, error=0
- Combinational outputs while reset_L=0:
  - wr_en=0, rd_en=0
  - empty=1, full=0, almost_empty=1, almost_full=0
- Reset mid-operation discards all contents and flags in that cycle. Requests during reset are ignored and are not counted as errors.
- Strobe latency: 0 cycles from push/pop.
- Pointer, count and flag latency: 1 cycle after the strobe's posedge.
- Read latency: the pop is accepted in cycle N; data_out and data_valid are valid in cycle N+1.
- Back-to-back pops every cycle give continuous data_valid.

## Configuration
- Macro: FIFO_CTRL_ERROR_EN.
- Defined:
  - error is a sticky register, set on any overflow or underflow event.
  - It is cleared only by reset and is visible the cycle after the event.
- Undefined:
  - The error port still exists and is tied to constant 0; no error logic is generated.
  - Rejection of illegal push/pop is identical in both builds.

## Structure
- Shared package fifo_pkg holds the following, used by this block and the storage array:
  - default MEM_DEPTH (8) and WORD_SIZE (10) constants
  - the derived PTR_SIZE/CNT_SIZE calculation
- One natural sub-module, fifo_ptr: a PTR_SIZE-bit wrap-around counter with synchronous active-low reset and an increment enable. It is instantiated twice, for the write pointer and the read pointer.
- Count, flag decode, data_valid and error logic stay in fifo_ctrl.

## Test plan
- Reset then idle: hold reset_L=0 for 2 cycles, then release → wr_ptr=rd_ptr=0, count=0, empty=1, full=0, data_valid=0, error=0.
- Fill and wrap: push for 8 cycles (MEM_DEPTH=8, umbral_alto=6) → wr_ptr sequence 1..7,0, count reaches 8, full=1 after the 8th push, almost_full=1 once count=6.
- Overflow: when full, push with no pop → wr_en=0, count stays 8, wr_ptr unchanged; error=1 next cycle with FIFO_CTRL_ERROR_EN, 0 without.
- Simultaneous push+pop at full and at empty:
  - full → both strobes high, count stays 8, both pointers advance.
  - empty → only wr_en high, count=1.
- Drain and underflow: pop 9 times from full (umbral_bajo=2) → data_valid high for 8 cycles, each one cycle after rd_en; rd_ptr wraps to 0; almost_empty=1 at count ≤ 2; 9th pop gives rd_en=0 and error set if enabled.
- Reset mid-operation: with count=5, assert reset_L=0 for 1 cycle → count=0, pointers 0, error cleared, data_valid=0 next cycle.
